// File: rtl/oam_dma.sv
// OAM sprite DMA: a CPU write to $4014 stalls the CPU and copies page $XX00-$XXFF to $2004.
// Define OAM_DMA_ALIGN_EN to insert the ALIGN cycle that puts every READ on parity 0.
module oam_dma (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_d_out,
    input  logic        cpu_rw,
    output logic        cpu_rdy,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_d_out,
    input  logic [7:0]  bus_d_in,
    output logic        bus_rw,
    output logic        dma_active,
    output logic        dma_done
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HALT  = 3'd1;
    localparam logic [2:0] ALIGN = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;

    logic [2:0] state;
    logic [2:0] state_next;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data;
    logic       parity;
    logic       start;

    // $4014 writes are only honoured in IDLE, so a running transfer keeps its page.
    assign start = (state == IDLE) && (cpu_a == 16'h4014) && !cpu_rw;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = HALT;
            HALT: begin
                // A CPU write cycle cannot be stalled, so HALT waits for a read cycle.
                if (cpu_rw) begin
`ifdef OAM_DMA_ALIGN_EN
                    state_next = parity ? READ : ALIGN;
`else
                    state_next = READ;
`endif
                end
            end
            ALIGN: state_next = READ;
            READ:  state_next = WRITE;
            WRITE: state_next = (idx == 8'hFF) ? IDLE : READ;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            page     <= '0;
            idx      <= '0;
            data     <= '0;
            parity   <= 1'b0;
            dma_done <= 1'b0;
        end else begin
            state    <= state_next;
            parity   <= ~parity;
            dma_done <= (state == WRITE) && (idx == 8'hFF);
            if (start) begin
                page <= cpu_d_out;
                idx  <= '0;
            end
            if (state == READ)
                data <= bus_d_in;
            if (state == WRITE)
                idx <= idx + 8'd1;
        end
    end

    always_comb begin
        cpu_rdy    = (state == IDLE);
        dma_active = (state != IDLE);
        bus_a      = cpu_a;
        bus_rw     = cpu_rw;
        bus_d_out  = cpu_d_out;
        case (state)
            READ: begin
                bus_a  = {page, idx};
                bus_rw = 1'b1;
            end
            WRITE: begin
                bus_a     = 16'h2004;
                bus_rw    = 1'b0;
                bus_d_out = data;
            end
            default: ;
        endcase
    end

endmodule
